// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS 32-bit registers, the last one a read-only status word.
// Independent AW/W capture with byte strobes, registered single-outstanding read response.
module axi4_lite_reg_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDRESS    = 32,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDRESS-1:0]      S_AWADDR,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic [1:0]              S_BRESP,
    output logic                    S_BVALID,
    input  logic                    S_BREADY,
    input  logic [ADDRESS-1:0]      S_ARADDR,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic                    S_RVALID,
    input  logic                    S_RREADY,
    input  logic [DATA_WIDTH-1:0]   status_in,
    output logic [DATA_WIDTH-1:0]   ctrl_out
);
    localparam int unsigned     IdxW       = $clog2(NUM_REGS);
    localparam int unsigned     NumBytes   = DATA_WIDTH / 8;
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_REGS - 1);
    localparam logic [1:0]      RespOkay   = 2'b00;
    localparam logic [1:0]      RespSlvErr = 2'b10;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic [IdxW-1:0]       aw_idx_q;
    logic                  aw_ok_q, aw_held_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [NumBytes-1:0]   w_strb_q;
    logic                  w_held_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic                  aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic                  aw_in_range, ar_in_range;
    logic [IdxW-1:0]       ar_idx;
    logic [DATA_WIDTH-1:0] ar_data;
    logic                  unused_addr_bits;

    // Byte offset within a word carries no meaning for this bank.
    assign unused_addr_bits = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

    assign S_AWREADY = !ARESET && !aw_held_q && !bvalid_q;
    assign S_WREADY  = !ARESET && !w_held_q && !bvalid_q;
    assign S_ARREADY = !ARESET && !rvalid_q;
    assign S_BVALID  = bvalid_q;
    assign S_BRESP   = bresp_q;
    assign S_RVALID  = rvalid_q;
    assign S_RDATA   = rdata_q;
    assign S_RRESP   = rresp_q;
    assign ctrl_out  = regs_q[0];

    assign aw_hs       = S_AWVALID && S_AWREADY;
    assign w_hs        = S_WVALID && S_WREADY;
    assign ar_hs       = S_ARVALID && S_ARREADY;
    assign commit      = aw_held_q && w_held_q;
    assign wr_ok       = aw_ok_q && (aw_idx_q != LastIdx);
    assign aw_in_range = (S_AWADDR[ADDRESS-1:IdxW+2] == '0);
    assign ar_in_range = (S_ARADDR[ADDRESS-1:IdxW+2] == '0);
    assign ar_idx      = S_ARADDR[IdxW+1:2];

    always_comb begin
        ar_data = regs_q[ar_idx];
        if (ar_idx == LastIdx) begin
            ar_data = status_in;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_idx_q  <= '0;
            aw_ok_q   <= 1'b0;
            aw_held_q <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
        end else begin
            if (aw_hs) begin
                aw_idx_q  <= S_AWADDR[IdxW+1:2];
                aw_ok_q   <= aw_in_range;
                aw_held_q <= 1'b1;
            end
            if (w_hs) begin
                w_data_q <= S_WDATA;
                w_strb_q <= S_WSTRB;
                w_held_q <= 1'b1;
            end
            // Readies are closed while anything is held or BVALID is up, so no capture races this.
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_ok ? RespOkay : RespSlvErr;
            end else if (bvalid_q && S_BREADY) begin
                bvalid_q <= 1'b0;
                bresp_q  <= RespOkay;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit && wr_ok) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
                if (w_strb_q[b]) begin
                    regs_q[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    // Sampling regs_q here yields the pre-write value when a commit lands on the same edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RespOkay;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            if (ar_in_range) begin
                rdata_q <= ar_data;
                rresp_q <= RespOkay;
            end else begin
                rdata_q <= '0;
                rresp_q <= RespSlvErr;
            end
        end else if (rvalid_q && S_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave: expected B/R responses are queued at issue time and
// checked by an independent monitor whenever a response handshake occurs.
module tb_axi4_lite_reg_slave;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] S_AWADDR;
    logic        S_AWVALID;
    logic        S_AWREADY;
    logic [31:0] S_WDATA;
    logic [3:0]  S_WSTRB;
    logic        S_WVALID;
    logic        S_WREADY;
    logic [1:0]  S_BRESP;
    logic        S_BVALID;
    logic        S_BREADY;
    logic [31:0] S_ARADDR;
    logic        S_ARVALID;
    logic        S_ARREADY;
    logic [31:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        S_RVALID;
    logic        S_RREADY;
    logic [31:0] status_in;
    logic [31:0] ctrl_out;

    int checks = 0;
    int errors = 0;

    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    axi4_lite_reg_slave #(
        .DATA_WIDTH(32),
        .ADDRESS   (32),
        .NUM_REGS  (8)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .S_AWADDR (S_AWADDR),
        .S_AWVALID(S_AWVALID),
        .S_AWREADY(S_AWREADY),
        .S_WDATA  (S_WDATA),
        .S_WSTRB  (S_WSTRB),
        .S_WVALID (S_WVALID),
        .S_WREADY (S_WREADY),
        .S_BRESP  (S_BRESP),
        .S_BVALID (S_BVALID),
        .S_BREADY (S_BREADY),
        .S_ARADDR (S_ARADDR),
        .S_ARVALID(S_ARVALID),
        .S_ARREADY(S_ARREADY),
        .S_RDATA  (S_RDATA),
        .S_RRESP  (S_RRESP),
        .S_RVALID (S_RVALID),
        .S_RREADY (S_RREADY),
        .status_in(status_in),
        .ctrl_out (ctrl_out)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge ACLK) begin
        if (!ARESET && S_BVALID && S_BREADY) begin
            if (bq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got bresp %b expected no response", S_BRESP);
            end else begin
                chk("bresp", {30'b0, S_BRESP}, {30'b0, bq.pop_front()});
            end
        end
        if (!ARESET && S_RVALID && S_RREADY) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL r_unexpected: got rdata 0x%08h expected no response", S_RDATA);
            end else begin
                logic [33:0] e;
                e = rq.pop_front();
                chk("rdata", S_RDATA, e[33:2]);
                chk("rresp", {30'b0, S_RRESP}, {30'b0, e[1:0]});
            end
        end
    end

    task automatic wait_idle();
        int c = 0;
        while ((bq.size() != 0 || rq.size() != 0) && c < 30) begin
            @(negedge ACLK);
            c++;
        end
        if (bq.size() != 0 || rq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", bq.size(), rq.size());
            bq.delete();
            rq.delete();
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        bq.push_back(resp);
        S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb;
        S_AWVALID = 1'b1; S_WVALID = 1'b1;
        for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
            @(negedge ACLK);
            aw_hs = S_AWVALID && S_AWREADY;
            w_hs  = S_WVALID && S_WREADY;
            @(posedge ACLK);
            #1;
            if (aw_hs) begin aw_done = 1; S_AWVALID = 1'b0; end
            if (w_hs)  begin w_done  = 1; S_WVALID  = 1'b0; end
        end
        if (!(aw_done && w_done)) begin
            checks++;
            errors++;
            $display("FAIL write_hs_timeout: got aw=%0d w=%0d expected 1/1", aw_done, w_done);
            S_AWVALID = 1'b0; S_WVALID = 1'b0;
            void'(bq.pop_back());
        end else begin
            chk1("bvalid_early", S_BVALID, 1'b0);
            @(posedge ACLK);
            #1;
            chk1("bvalid_rise", S_BVALID, 1'b1);
        end
        wait_idle();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        bit done = 0;
        bit hs;
        rq.push_back({data, resp});
        S_ARADDR = addr; S_ARVALID = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge ACLK);
            hs = S_ARVALID && S_ARREADY;
            @(posedge ACLK);
            #1;
            if (hs) begin done = 1; S_ARVALID = 1'b0; end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL read_hs_timeout: got no AR handshake expected one");
            S_ARVALID = 1'b0;
            void'(rq.pop_back());
        end else begin
            chk1("rvalid_rise", S_RVALID, 1'b1);
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1;
        S_AWADDR = '0; S_WDATA = '0; S_WSTRB = '0; S_ARADDR = '0;
        S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
        S_BREADY = 1'b1; S_RREADY = 1'b1;
        status_in = 32'h0;

        // Reset: everything low even with VALIDs asserted
        #12;
        chk1("rst_awready", S_AWREADY, 1'b0);
        chk1("rst_wready", S_WREADY, 1'b0);
        chk1("rst_arready", S_ARREADY, 1'b0);
        chk1("rst_bvalid", S_BVALID, 1'b0);
        chk1("rst_rvalid", S_RVALID, 1'b0);
        chk("rst_rdata", S_RDATA, 32'h0);
        chk("rst_resps", {28'b0, S_BRESP, S_RRESP}, 32'h0);
        chk("rst_ctrl", ctrl_out, 32'h0);
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        chk1("rel_awready", S_AWREADY, 1'b1);
        chk1("rel_wready", S_WREADY, 1'b1);
        chk1("rel_arready", S_ARREADY, 1'b1);
        @(posedge ACLK);
        #1;

        // Full write then read
        do_write(32'h04, 32'hDEADBEEF, 4'hF, OK);
        do_read(32'h04, 32'hDEADBEEF, OK);

        // Read and commit to the same register on the same edge: read sees old value
        bq.push_back(OK);
        rq.push_back({32'hDEADBEEF, OK});
        S_AWADDR = 32'h04; S_WDATA = 32'h01020304; S_WSTRB = 4'hF;
        S_AWVALID = 1'b1; S_WVALID = 1'b1;
        @(posedge ACLK);
        #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        S_ARADDR = 32'h04; S_ARVALID = 1'b1;
        @(posedge ACLK);
        #1;
        S_ARVALID = 1'b0;
        chk1("same_edge_bvalid", S_BVALID, 1'b1);
        chk1("same_edge_rvalid", S_RVALID, 1'b1);
        wait_idle();
        do_read(32'h04, 32'h01020304, OK);

        // Byte strobes
        do_write(32'h08, 32'h11223344, 4'hF, OK);
        do_write(32'h08, 32'hAABBCCDD, 4'b0101, OK);
        do_read(32'h08, 32'h11BB33DD, OK);

        // W before AW
        bq.push_back(OK);
        S_WDATA = 32'h5; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        @(posedge ACLK);
        #1;
        S_WVALID = 1'b0;
        chk1("wfirst_wready_e1", S_WREADY, 1'b0);
        @(posedge ACLK);
        #1;
        chk1("wfirst_wready_e2", S_WREADY, 1'b0);
        @(posedge ACLK);
        #1;
        chk1("wfirst_wready_e3", S_WREADY, 1'b0);
        S_AWADDR = 32'h00; S_AWVALID = 1'b1;
        @(posedge ACLK);
        #1;
        S_AWVALID = 1'b0;
        chk1("wfirst_wready_e4", S_WREADY, 1'b0);
        chk1("wfirst_bvalid_e4", S_BVALID, 1'b0);
        chk("wfirst_ctrl_e4", ctrl_out, 32'h0);
        @(posedge ACLK);
        #1;
        chk1("wfirst_bvalid_e5", S_BVALID, 1'b1);
        chk("wfirst_ctrl_e5", ctrl_out, 32'h5);
        wait_idle();

        // Error responses
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, ERR);
        do_read(32'h00, 32'h5, OK);
        do_read(32'h04, 32'h01020304, OK);
        do_write(32'h1C, 32'hFFFFFFFF, 4'hF, ERR);
        status_in = 32'hCAFE0001;
        do_read(32'h1C, 32'hCAFE0001, OK);
        do_read(32'h40, 32'h0, ERR);
        do_read(32'h80000004, 32'h0, ERR);
        do_read(32'h05, 32'h01020304, OK);
        chk("ctrl_after_err", ctrl_out, 32'h5);

        // Read backpressure; status sampled at the AR handshake
        S_RREADY = 1'b0;
        rq.push_back({32'hCAFE0001, OK});
        S_ARADDR = 32'h1C; S_ARVALID = 1'b1;
        @(posedge ACLK);
        #1;
        S_ARVALID = 1'b0;
        status_in = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk1("bp_rvalid", S_RVALID, 1'b1);
            chk("bp_rdata", S_RDATA, 32'hCAFE0001);
            chk1("bp_arready", S_ARREADY, 1'b0);
            @(posedge ACLK);
            #1;
        end
        S_RREADY = 1'b1;
        wait_idle();

        // Reset while BVALID is up: response discarded, register cleared
        S_BREADY = 1'b0;
        S_AWADDR = 32'h00; S_WDATA = 32'h12345678; S_WSTRB = 4'hF;
        S_AWVALID = 1'b1; S_WVALID = 1'b1;
        @(posedge ACLK);
        #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        for (int c = 0; c < 10 && !S_BVALID; c++) begin
            @(posedge ACLK);
            #1;
        end
        chk1("mid_bvalid_pre", S_BVALID, 1'b1);
        chk("mid_ctrl_pre", ctrl_out, 32'h12345678);
        #2;
        ARESET = 1'b1;
        #1;
        chk1("mid_bvalid_rst", S_BVALID, 1'b0);
        chk("mid_ctrl_rst", ctrl_out, 32'h0);
        chk1("mid_awready_rst", S_AWREADY, 1'b0);
        chk1("mid_arready_rst", S_ARREADY, 1'b0);
        @(negedge ACLK);
        ARESET = 1'b0;
        S_BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        chk1("mid_bvalid_after", S_BVALID, 1'b0);
        do_read(32'h00, 32'h0, OK);
        do_read(32'h04, 32'h0, OK);

        chk("leftover_b", bq.size(), 32'h0);
        chk("leftover_r", rq.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
